// File: rtl/spi_rx_cntrl.sv
// SPI peripheral-side receiver: synchronises SEN/SCLK/SDATA into wb_clk_i, shifts
// MSB-first words and buffers them in a first-word-fall-through FIFO with status flags.
module spi_rx_cntrl #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            enable,
  input  logic                            clear,
  input  logic                            SEN,
  input  logic                            SCLK,
  input  logic                            SDATA,
  input  logic                            fifo_rden,
  output logic [WIDTH-1:0]                data_out,
  output logic                            data_full,
  output logic                            data_empty,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            busy,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_t;

  state_t           state, state_nxt;
  logic             sen_s1, sen_s2;
  logic             sclk_s1, sclk_s2, sclk_s3;
  logic             sdata_s1, sdata_s2;
  logic             sen_s, sclk_rise, sdata_s;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-2:0] shift;
  logic [WIDTH-1:0] push_word;
  logic             last_bit;
  logic             shift_en, cnt_clr, ferr_set, push, pop_ok;
  logic [LW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];

  // Two-flop synchronisers; SCLK gets a third flop for rising-edge detection
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sen_s1   <= 1'b1;
      sen_s2   <= 1'b1;
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      sen_s1   <= SEN;
      sen_s2   <= sen_s1;
      sclk_s1  <= SCLK;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      sdata_s1 <= SDATA;
      sdata_s2 <= sdata_s1;
    end
  end

  assign sen_s     = sen_s2;
  assign sdata_s   = sdata_s2;
  assign sclk_rise = sclk_s2 & ~sclk_s3;
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
  assign push_word = {shift, sdata_s};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = sen_s ? IDLE : WAIT_END;
    end else begin
      case (state)
        IDLE:     if (!sen_s) state_nxt = enable ? SHIFT : WAIT_END;
        SHIFT:    if (!enable) state_nxt = WAIT_END;
                  else if (sen_s) state_nxt = IDLE;
        WAIT_END: if (sen_s) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // A bit arriving with SEN's rise is shifted first; the frame end is judged on the updated count
  always_comb begin
    shift_en = 1'b0;
    cnt_clr  = 1'b0;
    ferr_set = 1'b0;
    push     = 1'b0;
    busy     = (state == SHIFT);
    if (clear) begin
      cnt_clr = 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          if (!enable) begin
            cnt_clr = 1'b1;
          end else begin
            shift_en = sclk_rise;
            push     = sclk_rise & last_bit;
            if (sen_s) begin
              cnt_clr  = 1'b1;
              ferr_set = sclk_rise ? !last_bit : (bit_cnt != '0);
            end
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      if (shift_en) shift <= push_word[WIDTH-2:0];
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= last_bit ? '0 : CW'(bit_cnt + 1'b1);
    end
  end

  assign fifo_level = wr_ptr - rd_ptr;
  assign data_full  = (fifo_level == LW'(FIFO_DEPTH));
  assign data_empty = (fifo_level == '0);
  assign pop_ok     = fifo_rden & ~data_empty;
  assign data_out   = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO only lands when a pop frees the head in the same cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        if (!data_full || pop_ok) begin
          mem[wr_ptr[AW-1:0]] <= push_word;
          wr_ptr              <= wr_ptr + 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end
      if (pop_ok)   rd_ptr    <= rd_ptr + 1'b1;
      if (ferr_set) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_rx_cntrl.sv
// Bench for spi_rx_cntrl: table of single frames, directed corner sequences and
// random frames checked against a word-queue model of the receiver.
module tb_spi_rx_cntrl;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i, enable, clear, SEN, SCLK, SDATA, fifo_rden;
  logic [WIDTH-1:0] data_out;
  logic             data_full, data_empty, busy, frame_err, overflow;
  logic [LW-1:0]    fifo_level;

  spi_rx_cntrl #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .enable(enable), .clear(clear),
    .SEN(SEN), .SCLK(SCLK), .SDATA(SDATA), .fifo_rden(fifo_rden),
    .data_out(data_out), .data_full(data_full), .data_empty(data_empty),
    .fifo_level(fifo_level), .busy(busy), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int   n_vec = 0;
  int   n_bad = 0;
  logic bitq[$];

  typedef struct {
    int          nbits;
    logic [63:0] bits;
    int          exp_level;
    logic        exp_ferr;
    logic [31:0] exp_head;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  // Called at a negedge; one SCLK period is 8 wb_clk_i cycles
  task automatic send_bit(input logic b);
    SCLK = 1'b0; SDATA = b;
    repeat (4) @(negedge wb_clk_i);
    SCLK = 1'b1;
    repeat (4) @(negedge wb_clk_i);
  endtask

  task automatic send_frame();
    @(negedge wb_clk_i);
    SEN = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    while (bitq.size() > 0) send_bit(bitq.pop_front());
    SCLK = 1'b0; SEN = 1'b1;
    repeat (6) @(negedge wb_clk_i);
  endtask

  // 32-bit word whose last bit rises together with a fifo_rden pulse at the push cycle
  task automatic send_word_with_pop(input logic [31:0] v);
    @(negedge wb_clk_i);
    SEN = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    for (int i = 31; i >= 1; i--) send_bit(v[i]);
    SCLK = 1'b0; SDATA = v[0];
    repeat (4) @(negedge wb_clk_i);
    SCLK = 1'b1;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    fifo_rden = 1'b1;
    @(negedge wb_clk_i);
    fifo_rden = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    SCLK = 1'b0; SEN = 1'b1;
    repeat (6) @(negedge wb_clk_i);
  endtask

  task automatic pop();
    @(negedge wb_clk_i);
    fifo_rden = 1'b1;
    @(negedge wb_clk_i);
    fifo_rden = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge wb_clk_i);
    clear = 1'b1;
    @(negedge wb_clk_i);
    clear = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"},   64'(data_out),   64'd0);
    check({tag, "_full"},       64'(data_full),  64'd0);
    check({tag, "_empty"},      64'(data_empty), 64'd1);
    check({tag, "_level"},      64'(fifo_level), 64'd0);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_frame_err"},  64'(frame_err),  64'd0);
    check({tag, "_overflow"},   64'(overflow),   64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] mq[$];
    logic [31:0] acc;
    logic        m_ferr, m_ovf, b;
    int          cnt, n, lat;
    logic        seen;

    wb_rst_i = 1'b1; enable = 1'b1; clear = 1'b0; SEN = 1'b1; SCLK = 1'b0;
    SDATA = 1'b0; fifo_rden = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check_reset_values("reset");
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Table: each vector is a single frame after a clear
    tbl[0] = '{32, 64'h0000_0000_A5C3_0F96, 1, 1'b0, 32'hA5C3_0F96};
    tbl[1] = '{64, 64'h0000_0001_FFFF_FFFE, 2, 1'b0, 32'h0000_0001};
    tbl[2] = '{12, 64'h0000_0000_0000_0ABC, 0, 1'b1, 32'h0};
    tbl[3] = '{33, 64'h0000_0000_2468_ACF1, 1, 1'b1, 32'h1234_5678};
    tbl[4] = '{0,  64'h0,                   0, 1'b0, 32'h0};
    tbl[5] = '{31, 64'h0000_0000_7FFF_FFFF, 0, 1'b1, 32'h0};
    for (int i = 0; i < 6; i++) begin
      do_clear();
      load_bits(tbl[i].bits, tbl[i].nbits);
      send_frame();
      check($sformatf("tbl%0d_level", i), 64'(fifo_level), 64'(tbl[i].exp_level));
      check($sformatf("tbl%0d_ferr", i),  64'(frame_err),  64'(tbl[i].exp_ferr));
      check($sformatf("tbl%0d_empty", i), 64'(data_empty), 64'(tbl[i].exp_level == 0));
      check($sformatf("tbl%0d_busy", i),  64'(busy),       64'd0);
      if (tbl[i].exp_level > 0)
        check($sformatf("tbl%0d_head", i), 64'(data_out), 64'(tbl[i].exp_head));
    end
    do_clear();
    load_bits(64'h0000_0001_FFFF_FFFE, 64);
    send_frame();
    pop();
    check("b2b_second", 64'(data_out), 64'hFFFF_FFFE);
    pop();
    check("b2b_empty", 64'(data_empty), 64'd1);

    // Push latency of the last bit and busy while shifting
    do_clear();
    @(negedge wb_clk_i);
    SEN = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    for (int i = 31; i >= 1; i--) send_bit(lat_word(i));
    SCLK = 1'b0; SDATA = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    check("busy_in_frame", 64'(busy), 64'd1);
    SCLK = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 4 && !seen; k++) begin
      @(posedge wb_clk_i);
      #1;
      if (!data_empty) seen = 1'b1;
    end
    check("push_latency_le4", 64'(seen), 64'd1);
    repeat (4) @(negedge wb_clk_i);
    SCLK = 1'b0; SEN = 1'b1;
    repeat (6) @(negedge wb_clk_i);
    check("lat_head", 64'(data_out), 64'hA5C3_0F96);
    check("lat_busy_off", 64'(busy), 64'd0);

    // Partial frame then a good word: frame_err stays sticky
    do_clear();
    load_bits(64'hABC, 12);
    send_frame();
    check("partial_ferr", 64'(frame_err), 64'd1);
    check("partial_level", 64'(fifo_level), 64'd0);
    load_bits(64'h1234_5678, 32);
    send_frame();
    check("after_partial_head", 64'(data_out), 64'h1234_5678);
    check("after_partial_ferr", 64'(frame_err), 64'd1);

    // Overflow with no pops
    do_clear();
    for (int w = 1; w <= 5; w++) load_bits(64'(w), 32);
    send_frame();
    check("ovf_full", 64'(data_full), 64'd1);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_level", 64'(fifo_level), 64'd4);
    for (int w = 1; w <= 4; w++) begin
      check($sformatf("ovf_pop%0d", w), 64'(data_out), 64'(w));
      pop();
    end
    check("ovf_drained", 64'(data_empty), 64'd1);

    // Clear with a simultaneous pop: 3 words buffered, both flags set
    load_bits(64'hABC, 12);
    send_frame();
    for (int w = 1; w <= 5; w++) load_bits(64'(w), 32);
    send_frame();
    pop();
    check("pre_clear_level", 64'(fifo_level), 64'd3);
    @(negedge wb_clk_i);
    clear = 1'b1; fifo_rden = 1'b1;
    @(negedge wb_clk_i);
    clear = 1'b0; fifo_rden = 1'b0;
    check("clear_level", 64'(fifo_level), 64'd0);
    check("clear_empty", 64'(data_empty), 64'd1);
    check("clear_ovf", 64'(overflow), 64'd0);
    check("clear_ferr", 64'(frame_err), 64'd0);

    // Pop in the same cycle as the fifth push
    for (int w = 1; w <= 4; w++) load_bits(64'(w), 32);
    send_frame();
    send_word_with_pop(32'd5);
    check("pushpop_ovf", 64'(overflow), 64'd0);
    check("pushpop_level", 64'(fifo_level), 64'd4);
    for (int w = 2; w <= 5; w++) begin
      check($sformatf("pushpop_pop%0d", w), 64'(data_out), 64'(w));
      pop();
    end
    pop();
    check("pop_when_empty", 64'(fifo_level), 64'd0);

    // Drop enable mid-frame: no error, rest of frame ignored
    do_clear();
    for (int i = 0; i < 32; i++) bitq.push_back(1'b1);
    @(negedge wb_clk_i);
    SEN = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    for (int i = 0; i < 10; i++) send_bit(bitq.pop_front());
    enable = 1'b0;
    while (bitq.size() > 0) send_bit(bitq.pop_front());
    enable = 1'b1;
    SCLK = 1'b0; SEN = 1'b1;
    repeat (6) @(negedge wb_clk_i);
    check("en_drop_ferr", 64'(frame_err), 64'd0);
    check("en_drop_level", 64'(fifo_level), 64'd0);
    load_bits(64'hCAFE_F00D, 32);
    send_frame();
    check("en_drop_next", 64'(data_out), 64'hCAFE_F00D);

    // Asynchronous reset mid-word with a buffered word and sticky error
    load_bits(64'hABC, 12);
    send_frame();
    @(negedge wb_clk_i);
    SEN = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    #2 wb_rst_i = 1'b1;
    #1 check_reset_values("async_rst");
    SEN = 1'b1; SCLK = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Random frames against a word-queue model
    do_clear();
    mq.delete(); m_ferr = 1'b0; m_ovf = 1'b0;
    for (int f = 0; f < 14; f++) begin
      n = ($urandom_range(0, 2) == 0) ? 32 * int'($urandom_range(1, 2)) : int'($urandom_range(0, 70));
      acc = '0; cnt = 0;
      for (int i = 0; i < n; i++) begin
        b = 1'($urandom);
        bitq.push_back(b);
        acc = {acc[30:0], b};
        cnt++;
        if (cnt == WIDTH) begin
          if (mq.size() == DEPTH) m_ovf = 1'b1;
          else mq.push_back(acc);
          cnt = 0;
        end
      end
      if (cnt != 0) m_ferr = 1'b1;
      send_frame();
      check($sformatf("rnd%0d_level", f), 64'(fifo_level), 64'(mq.size()));
      check($sformatf("rnd%0d_ferr", f),  64'(frame_err),  64'(m_ferr));
      check($sformatf("rnd%0d_ovf", f),   64'(overflow),   64'(m_ovf));
      check($sformatf("rnd%0d_full", f),  64'(data_full),  64'(mq.size() == DEPTH));
      for (int p = int'($urandom_range(0, 3)); p > 0; p--) begin
        if (mq.size() > 0) begin
          check($sformatf("rnd%0d_head", f), 64'(data_out), 64'(mq[0]));
          void'(mq.pop_front());
        end
        pop();
      end
      check($sformatf("rnd%0d_level_post", f), 64'(fifo_level), 64'(mq.size()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  function automatic logic lat_word(input int i);
    logic [31:0] w;
    w = 32'hA5C3_0F96;
    return w[i];
  endfunction

endmodule

// File: doc/spi_rx_cntrl.md
Name: spi_rx_cntrl

Overview:
- SPI receiver (peripheral end) for the SEN/SCLK/SDATA link driven by spi0.
- Synchronises the three pins into the wb_clk_i domain and shifts SDATA in MSB-first on SCLK rising edges.
- Buffers complete WIDTH-bit words in a first-word-fall-through FIFO, exposed to the LA/wishbone side with full/empty/level and sticky error flags.

Parameters:
- WIDTH, 32, bits per word; words are contiguous while SEN is low.
- FIFO_DEPTH, 4, word entries; must be a power of 2 and at least 2.

Ports:
- wb_clk_i  input  1  system clock; must be at least 4x SCLK frequency.
- wb_rst_i  input  1  reset; asynchronous, active-high.
- enable  input  1  receiver enable; frames only start while high.
- clear  input  1  synchronous clear of the FIFO, sticky flags and any frame in progress.
- SEN  input  1  serial enable pin, active low; asynchronous to wb_clk_i.
- SCLK  input  1  serial clock pin; asynchronous to wb_clk_i.
- SDATA  input  1  serial data pin; asynchronous to wb_clk_i.
- fifo_rden  input  1  pop the head word; ignored when data_empty.
- data_out  output  WIDTH  FIFO head word; valid when data_empty=0.
- data_full  output  1  FIFO holds FIFO_DEPTH words.
- data_empty  output  1  FIFO holds 0 words.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of words held.
- busy  output  1  high in SHIFT state.
- frame_err  output  1  sticky; SEN rose with a partial word captured.
- overflow  output  1  sticky; a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, wb_rst_i=1):
  - State IDLE; bit counter, shift register and pointers all 0.
  - data_out=0, data_full=0, data_empty=1, fifo_level=0, busy=0, frame_err=0, overflow=0.
  - Synchroniser flops reset to SEN=1, SCLK=0, SDATA=0.
- Synchronisation:
  - Each pin goes through a 2-flop synchroniser.
  - A third SCLK flop gives sclk_rise = sync2 & ~sync3.
  - Logic uses only synchronised values.
- State IDLE:
  - If enable=1 and SEN_s=0, go to SHIFT with bit_cnt=0.
  - If enable=0 and SEN_s=0, go to WAIT_END.
- State SHIFT:
  - On sclk_rise: shift = {shift[WIDTH-2:0], SDATA_s}, bit_cnt+1.
  - When the bit_cnt=WIDTH-1 bit is shifted in, the full word, including that bit, is pushed the same cycle and bit_cnt wraps to 0. The state stays SHIFT, so back-to-back words under one SEN low are allowed.
  - On SEN_s=1: if bit_cnt!=0, set frame_err and discard the partial word; go to IDLE.
  - sclk_rise and SEN_s rise in the same cycle: shift the bit first, then evaluate the frame end against the updated count. A word completed by that bit is pushed, with no error.
  - enable=0 mid-frame: discard the partial word without an error flag; go to WAIT_END.
- State WAIT_END:
  - Ignore SCLK.
  - Go to IDLE when SEN_s=1.
- Push latency: data_empty falls at most 4 wb_clk_i edges after the pin-level SCLK rise carrying the last bit (2 sync + 1 edge register + 1 write).
- FIFO:
  - FWFT: data_out = mem[rd_ptr] and is stable until popped.
  - fifo_level = wr_ptr - rd_ptr, using pointers one bit wider than the address.
  - Push when full with no pop in the same cycle: word dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle when full: both take effect, no overflow, level unchanged.
  - Push and pop in the same cycle when empty: the pop is ignored, the push succeeds, level becomes 1.
  - fifo_rden while empty has no effect.
- clear=1 (synchronous, one cycle):
  - Empties the FIFO, clears frame_err and overflow, zeroes bit_cnt.
  - If SEN_s=0 the next state is WAIT_END, otherwise IDLE.
  - clear has priority over a push and a pop in the same cycle.
- Sticky flags only clear on reset or clear.

Test Plan:
- Single word: enable=1, SEN low, 32 SCLK pulses (8 wb_clk_i per SCLK period) sending 0xA5C3_0F96 MSB-first, then SEN high. Required: data_empty falls within 4 cycles of the 32nd rise; data_out=0xA5C30F96; fifo_level=1; frame_err=0; busy returns to 0.
- Back-to-back words: one SEN-low frame of 64 bits, 0x00000001 then 0xFFFFFFFE. Required: fifo_level=2; pops return 0x00000001 then 0xFFFFFFFE; data_empty=1 after the second pop.
- Partial frame: SEN low, 12 SCLK pulses, SEN high. Required: frame_err=1, fifo_level=0. A following valid word 0x12345678 is received correctly and frame_err stays 1 until clear.
- Overflow: send 5 words 1..5 with no pops (FIFO_DEPTH=4). Required: data_full=1, overflow=1, and pops yield 1, 2, 3, 4. Repeat with fifo_rden pulsed in the same cycle as the 5th push: overflow=0, final contents 2..5.
- Mid-frame disruptions:
  - Drop enable after 10 bits: no frame_err; remaining SCLKs ignored until SEN high; the next frame is received correctly.
  - Assert wb_rst_i asynchronously mid-word: all outputs at reset values immediately, with no clock edge.
- Clear: 3 words buffered, overflow=1, then pulse clear together with fifo_rden. Required next cycle: fifo_level=0, data_empty=1, overflow=0, frame_err=0.
